// File: rtl/dma_desc_queue_pkg.sv
// dma_pkg: shared types and constants for the DMA descriptor front end.
//   dma_desc_t  - 96-bit descriptor as stored in the queue (MSB first)
//   REG_*       - register word offsets on the reg_addr port
//   CTRL_*      - bit positions in a CTRL write
//   STAT_*      - bit positions in a STATUS read
package dma_pkg;

  typedef struct packed {
    logic [31:0] src;     // [95:64]
    logic [31:0] dst;     // [63:32]
    logic [7:0]  src_lo;  // [31:24]
    logic [7:0]  dst_lo;  // [23:16]
    logic [7:0]  len_lo;  // [15:8]
    logic [7:0]  tag;     // [7:0]
  } dma_desc_t;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int unsigned CTRL_PUSH    = 0;
  localparam int unsigned CTRL_FLUSH   = 1;
  localparam int unsigned CTRL_CLR_OVF = 2;
  localparam int unsigned CTRL_CLR_IRQ = 3;

  localparam int unsigned STAT_EMPTY = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_OVF   = 2;
  localparam int unsigned STAT_IRQ   = 3;

endpackage

// File: rtl/dma_desc_queue_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with flush.
//   clk, rst     - clock, asynchronous active-high reset
//   push, wdata  - write an entry (ignored when full unless pop is also taken)
//   pop          - advance the head (ignored when empty)
//   flush        - empty the FIFO; overrides push and pop
//   rdata        - head entry, valid while !empty
//   full, empty  - derived from the registered count
//   count        - occupancy 0..DEPTH
module sync_fifo #(
  parameter  int unsigned WIDTH = 96,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_desc_queue.sv
// dma_desc_queue: register front end that packs descriptors into a FIFO
// feeding the DMA controller.
//   clk, rst            - clock, asynchronous active-high reset
//   reg_wr, reg_rd      - one-cycle register write / read strobes
//   reg_addr            - 0 SRC, 1 DST, 2 LEN, 3 CTRL(write)/STATUS(read)
//   reg_wdata           - write data; CTRL bits [0] push [1] flush
//                         [2] clear overflow [3] clear irq
//   reg_rdata           - registered read data, 0 when no read
//   desc_data           - head descriptor (valid while !fifo_empty)
//   desc_pop            - consumer takes the head
//   fifo_empty/full     - queue flags
//   fifo_count          - occupancy
//   irq                 - interrupt level
// Build option: define DMA_DESC_IRQ_EN to enable irq (set on a pop that
// drains the queue or on overflow). Without it irq is tied low.
module dma_desc_queue
  import dma_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic [95:0]      desc_data,
  input  logic             desc_pop,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [CNT_W-1:0] fifo_count,
  output logic             irq
);

  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [31:0] len_q;
  logic [7:0]  tag_q;
  logic        ovf_q;

  logic        ctrl_wr;
  logic        push_req;
  logic        flush;
  logic        clr_ovf;
  logic        pop_ok;
  logic        push_ok;
  logic        ovf_event;
  logic        irq_bit;
  dma_desc_t   desc_in;

  assign ctrl_wr  = reg_wr && (reg_addr == REG_CTRL);
  assign push_req = ctrl_wr && reg_wdata[CTRL_PUSH];
  assign flush    = ctrl_wr && reg_wdata[CTRL_FLUSH];
  assign clr_ovf  = ctrl_wr && reg_wdata[CTRL_CLR_OVF];

  // Flush swallows both sides of the queue in the same cycle.
  assign pop_ok    = desc_pop && !fifo_empty && !flush;
  assign push_ok   = push_req && !flush && (!fifo_full || pop_ok);
  assign ovf_event = push_req && !flush && fifo_full && !pop_ok;

  always_comb begin
    desc_in        = '0;
    desc_in.src    = src_q;
    desc_in.dst    = dst_q;
    desc_in.src_lo = src_q[7:0];
    desc_in.dst_lo = dst_q[7:0];
    desc_in.len_lo = len_q[7:0];
    desc_in.tag    = tag_q;
  end

  sync_fifo #(
    .WIDTH (96),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop_ok),
    .flush (flush),
    .wdata (desc_in),
    .rdata (desc_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else if (reg_wr) begin
      case (reg_addr)
        REG_SRC: src_q <= reg_wdata;
        REG_DST: dst_q <= reg_wdata;
        REG_LEN: len_q <= reg_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) tag_q <= tag_q + 8'd1;
      if (ovf_event)    ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

`ifdef DMA_DESC_IRQ_EN
  logic irq_q;
  logic irq_set;
  logic clr_irq;

  assign clr_irq = ctrl_wr && reg_wdata[CTRL_CLR_IRQ];
  // Draining pop: last entry leaves with no refill in the same cycle.
  assign irq_set = ovf_event ||
                   (pop_ok && !push_ok && (fifo_count == CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          irq_q <= 1'b0;
    else if (irq_set) irq_q <= 1'b1;
    else if (clr_irq) irq_q <= 1'b0;
  end

  assign irq     = irq_q;
  assign irq_bit = irq_q;
`else
  assign irq     = 1'b0;
  assign irq_bit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_rdata <= '0;
    end else if (reg_rd) begin
      case (reg_addr)
        REG_SRC: reg_rdata <= src_q;
        REG_DST: reg_rdata <= dst_q;
        REG_LEN: reg_rdata <= len_q;
        default: begin
          reg_rdata                <= '0;
          reg_rdata[STAT_EMPTY]    <= fifo_empty;
          reg_rdata[STAT_FULL]     <= fifo_full;
          reg_rdata[STAT_OVF]      <= ovf_q;
          reg_rdata[STAT_IRQ]      <= irq_bit;
          reg_rdata[15:8]          <= 8'(fifo_count);
          reg_rdata[23:16]         <= tag_q;
        end
      endcase
    end else begin
      reg_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_dma_desc_queue.sv
// Testbench for dma_desc_queue: directed scenarios followed by a random
// phase, with descriptors queued in a scoreboard as pushes are accepted and
// compared against desc_data when the consumer pops them.
module tb_dma_desc_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             reg_wr;
  logic             reg_rd;
  logic [1:0]       reg_addr;
  logic [31:0]      reg_wdata;
  logic [31:0]      reg_rdata;
  logic [95:0]      desc_data;
  logic             desc_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             irq;

  dma_desc_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .desc_data  (desc_data),
    .desc_pop   (desc_pop),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference state
  logic [95:0] sb[$];
  logic [31:0] m_src, m_dst, m_len;
  logic [7:0]  m_tag;
  logic        m_ovf;
  logic        m_irq;

  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_src = '0; m_dst = '0; m_len = '0;
    m_tag = '0; m_ovf = 1'b0; m_irq = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, 96'(reg_rdata), 96'h0);
    check({tag, "_desc"},  desc_data, 96'h0);
    check({tag, "_empty"}, 96'(fifo_empty), 96'h1);
    check({tag, "_full"},  96'(fifo_full), 96'h0);
    check({tag, "_count"}, 96'(fifo_count), 96'h0);
    check({tag, "_irq"},   96'(irq), 96'h0);
  endtask

  // One clock cycle of stimulus; the model advances alongside.
  task automatic step(input logic wr, input logic [1:0] addr, input logic [31:0] wd,
                      input logic rd, input logic pop);
    logic        c_push, c_flush, c_clr_ovf, c_clr_irq;
    logic        pop_eff, push_acc, ovf_ev, irq_set, was_full;
    int          sz;
    logic [31:0] exp_rd;
    logic [95:0] d;

    @(negedge clk);
    c_push    = wr && addr == 2'd3 && wd[0];
    c_flush   = wr && addr == 2'd3 && wd[1];
    c_clr_ovf = wr && addr == 2'd3 && wd[2];
    c_clr_irq = wr && addr == 2'd3 && wd[3];
    sz        = sb.size();
    was_full  = (sz == DEPTH);
    pop_eff   = pop && sz != 0 && !c_flush;

    if (pop && sz != 0) check("head", desc_data, sb[0]);

    case (addr)
      2'd0: exp_rd = m_src;
      2'd1: exp_rd = m_dst;
      2'd2: exp_rd = m_len;
      default: begin
        exp_rd = '0;
        exp_rd[0] = (sz == 0);
        exp_rd[1] = was_full;
        exp_rd[2] = m_ovf;
`ifdef DMA_DESC_IRQ_EN
        exp_rd[3] = m_irq;
`endif
        exp_rd[15:8]  = 8'(sz);
        exp_rd[23:16] = m_tag;
      end
    endcase
    if (!rd) exp_rd = '0;

    d = {m_src, m_dst, m_src[7:0], m_dst[7:0], m_len[7:0], m_tag};

    reg_wr = wr; reg_addr = addr; reg_wdata = wd; reg_rd = rd; desc_pop = pop;
    @(posedge clk);

    push_acc = 1'b0;
    ovf_ev   = 1'b0;
    if (c_flush) begin
      sb.delete();
    end else begin
      if (pop_eff) void'(sb.pop_front());
      if (c_push) begin
        if (!was_full || pop_eff) begin
          sb.push_back(d);
          m_tag    = m_tag + 8'd1;
          push_acc = 1'b1;
        end else begin
          ovf_ev = 1'b1;
        end
      end
    end
    if (ovf_ev) m_ovf = 1'b1;
    else if (c_clr_ovf) m_ovf = 1'b0;
    irq_set = ovf_ev || (pop_eff && !push_acc && sz == 1);
`ifdef DMA_DESC_IRQ_EN
    if (irq_set) m_irq = 1'b1;
    else if (c_clr_irq) m_irq = 1'b0;
`else
    m_irq = 1'b0;
`endif
    if (wr && addr == 2'd0) m_src = wd;
    if (wr && addr == 2'd1) m_dst = wd;
    if (wr && addr == 2'd2) m_len = wd;

    #1;
    reg_wr = 1'b0; reg_rd = 1'b0; desc_pop = 1'b0; reg_wdata = '0; reg_addr = '0;
    check("count", 96'(fifo_count), 96'(sb.size()));
    check("empty", 96'(fifo_empty), 96'(sb.size() == 0));
    check("full",  96'(fifo_full),  96'(sb.size() == DEPTH));
    check("irq",   96'(irq), 96'(m_irq));
    check("rdata", 96'(reg_rdata), 96'(exp_rd));
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] v);
    step(1'b1, a, v, 1'b0, 1'b0);
  endtask

  task automatic rd_status();
    step(1'b0, 2'd3, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic pop1();
    step(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0;
    reg_wdata = '0; desc_pop = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // First descriptor, one-cycle push latency
    wr_reg(2'd0, 32'h1000_0044);
    wr_reg(2'd1, 32'h2000_0055);
    wr_reg(2'd2, 32'h0000_0010);
    wr_reg(2'd3, 32'h1);
    check("desc0", desc_data, 96'h1000_0044_2000_0055_4455_1000);
    check("staging_src", 96'(m_src), 96'h1000_0044);
    step(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 2'd2, 32'h0, 1'b1, 1'b0);

    // Identical push: tags distinguish the entries
    wr_reg(2'd3, 32'h1);
    check("head_tag0", 96'(desc_data[7:0]), 96'h00);
    pop1();
    check("head_tag1", 96'(desc_data[7:0]), 96'h01);
    pop1();
    pop1();                                  // pop while empty
    rd_status();
    wr_reg(2'd3, 32'h8);                     // clear irq
    rd_status();

    // Overflow on the fifth push
    repeat (5) wr_reg(2'd3, 32'h1);
    check("full_after5", 96'(fifo_full), 96'h1);
    rd_status();
    check("ovf_bit", 96'(reg_rdata[2]), 96'h1);
    wr_reg(2'd3, 32'h4);
    rd_status();
    check("ovf_clr", 96'(reg_rdata[2]), 96'h0);

    // Full: push and pop together
    wr_reg(2'd0, 32'hCAFE_00AA);
    step(1'b1, 2'd3, 32'h1, 1'b0, 1'b1);
    rd_status();
    check("ovf_pushpop", 96'(reg_rdata[2]), 96'h0);
    repeat (4) pop1();

    // Flush wins over push
    repeat (3) wr_reg(2'd3, 32'h1);
    wr_reg(2'd3, 32'h3);
    rd_status();
    wr_reg(2'd3, 32'h8);

    // Asynchronous reset mid-stream
    repeat (2) wr_reg(2'd3, 32'h1);
    rd_status();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [1:0]  a;
      logic [31:0] v;
      logic        w, r, p;
      a = 2'($urandom_range(0, 3));
      v = $urandom;
      if (a == 2'd3) begin
        v[0] = ($urandom_range(0, 2) != 0);
        v[1] = ($urandom_range(0, 15) == 0);
        v[2] = ($urandom_range(0, 3) == 0);
        v[3] = ($urandom_range(0, 3) == 0);
      end
      w = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 4) < 2);
      step(w, a, v, r, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
